rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource between REQ_NUM requesters.
- Grants exactly one requester at a time and holds the grant until that requester signals done, withdraws its request, or exceeds a hold limit.
- Next-winner selection is a masked lowest-set-bit search over the request vector. The search rotates fairness from the last-served index.

Parameters:
- REQ_NUM, 5, number of requesters (2..32).
- MAX_HOLD, 16, maximum consecutive cycles gnt_o may stay high. 0 = unlimited (no timeout).
- IDX_W, $clog2(REQ_NUM), width of the binary grant index (derived, do not override).

Ports:
- clk_i  in  1  single clock, rising edge.
- arst_n_i  in  1  reset, asynchronous assert, active-low.
- req_i  in  REQ_NUM  request vector; bit k = requester k wants the resource.
- done_i  in  1  granted requester releases the resource; sampled only while gnt_val_o=1.
- gnt_o  out  REQ_NUM  one-hot grant, registered.
- gnt_idx_o  out  IDX_W  binary index of the granted requester, registered.
- gnt_val_o  out  1  grant active (equals |gnt_o).
- timeout_o  out  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (arst_n_i=0, immediate, any state):
  - gnt_o=0, gnt_idx_o=0, gnt_val_o=0, timeout_o=0.
  - State=IDLE, hold_cnt=0.
  - last_ptr=REQ_NUM-1, so requester 0 has top priority after reset.
- States: IDLE, BUSY.
- IDLE:
  - If req_i==0: stay in IDLE, outputs 0.
  - Otherwise the winner is the lowest set index strictly above last_ptr. If none is set above last_ptr, wrap and take the lowest set index overall.
  - At that edge: gnt_o=onehot(winner), gnt_idx_o=winner, gnt_val_o=1, hold_cnt=0, go to BUSY.
  - Latency: request sampled at edge k, grant visible from edge k.
  - done_i is ignored in IDLE.
- BUSY (grant held, gnt_o stable), release conditions evaluated each edge in this priority:
  1. done_i=1.
  2. req_i[gnt_idx_o]=0 (request withdrawn).
  3. MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 (timeout).
- On release:
  - gnt_o=0, gnt_val_o=0, last_ptr=gnt_idx_o, go to IDLE.
  - gnt_idx_o keeps its last value.
  - timeout_o=1 for exactly one cycle only when condition 3 caused the release.
- If no release: hold_cnt++ (saturating, width $clog2(MAX_HOLD+1), min 1).
- With no early release, gnt_o is high exactly MAX_HOLD cycles.
- Release always inserts one IDLE cycle with gnt_o=0 before the next grant (turnaround bubble). This holds even if the same or another requester is pending.
- done_i and timeout on the same edge: done wins, timeout_o stays 0.
- req_i changes to non-granted bits during BUSY have no effect until IDLE.
- A single continuously requesting requester is re-granted after each bubble: grant, 1-cycle gap, grant.
- Invariant: gnt_o is zero or one-hot; gnt_val_o==|gnt_o.

Decomposition:
- Package arb_pkg:
  - typedef enum logic [0:0] {ST_IDLE, ST_BUSY} arb_state_t.
  - Function onehot_to_idx.
- Sub-module rr_pick, purely combinational:
  - Inputs: req, last_ptr.
  - Outputs: winner index, any_valid.
  - Implementation: mask bits <= last_ptr, take the lowest set bit of the masked vector, fall back to the unmasked vector.
- The FSM, hold counter and output registers live in rr_arbiter.

Test Plan (REQ_NUM=5, MAX_HOLD=4):
- Reset then req_i=5'b00001 held, done_i pulsed on the 3rd grant cycle -> gnt_o=00001 for 3 cycles, 1 bubble cycle, then 00001 again; timeout_o=0.
- req_i=5'b10101 constant, done_i pulsed 1 cycle after each grant -> grant order idx 0, 2, 4, 0, 2 with 1-cycle gaps; gnt_idx_o matches.
- req_i=5'b00110 constant, done_i=0 -> gnt_o=00010 exactly 4 cycles, timeout_o=1 on the release edge; then 00100 for 4 cycles, timeout_o pulses again.
- Grant idx 3 active with hold_cnt=3 and done_i=1 on the same edge -> release, timeout_o stays 0, next grant is idx 4 if requesting.
- Grant idx 1 active, req_i[1] drops to 0 while req_i[3]=1 -> gnt_o=0 next edge, then 01000 after the bubble; timeout_o=0.
- arst_n_i pulsed low mid-grant (gnt_o=00100) -> all outputs 0 immediately without a clock edge; after release with req_i=11111, the first grant is idx 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

  typedef enum logic [0:0] {ST_IDLE, ST_BUSY} arb_state_t;

  // Binary index of a one-hot vector (up to 32 requesters); OR-reduction keeps it small.
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] onehot);
    logic [4:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (onehot[i]) idx |= 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search: lowest request strictly above last_ptr,
// wrapping to the lowest request overall.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned REQ_NUM = 5,
  parameter int unsigned IDX_W   = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [IDX_W-1:0]   last_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  logic [REQ_NUM-1:0] w_mask;
  logic [REQ_NUM-1:0] w_masked;
  logic [REQ_NUM-1:0] w_src;
  logic [REQ_NUM-1:0] w_lowest;
  logic [31:0]        w_lowest_pad;

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      w_mask[i] = (i > int'(last_ptr));
    end
  end

  assign w_masked     = req & w_mask;
  assign w_src        = (|w_masked) ? w_masked : req;
  assign w_lowest     = w_src & (~w_src + REQ_NUM'(1));
  assign w_lowest_pad = 32'(w_lowest);
  assign winner       = IDX_W'(onehot_to_idx(w_lowest_pad));
  assign any_valid    = |req;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with hold-until-done grants, a hold-limit timeout and a
// one-cycle turnaround bubble after every release.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned REQ_NUM  = 5,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned IDX_W    = $clog2(REQ_NUM)
) (
  input  logic               clk_i,
  input  logic               arst_n_i,
  input  logic [REQ_NUM-1:0] req_i,
  input  logic               done_i,
  output logic [REQ_NUM-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_val_o,
  output logic               timeout_o
);

  localparam int unsigned     HC_W      = ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HC_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(REQ_NUM - 1);

  arb_state_t         r_state;
  logic [HC_W-1:0]    r_hold_cnt;
  logic [IDX_W-1:0]   r_last_ptr;
  logic [REQ_NUM-1:0] r_gnt;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic               r_timeout;

  logic [IDX_W-1:0]   w_winner;
  logic               w_any;
  logic               w_withdrawn;
  logic               w_hold_exp;

  rr_pick #(
    .REQ_NUM (REQ_NUM),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (req_i),
    .last_ptr  (r_last_ptr),
    .winner    (w_winner),
    .any_valid (w_any)
  );

  assign w_withdrawn = ~req_i[r_gnt_idx];
  assign w_hold_exp  = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_last_ptr <= PTR_RST;
      r_gnt      <= '0;
      r_gnt_idx  <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt      <= REQ_NUM'(1) << w_winner;
            r_gnt_idx  <= w_winner;
            r_hold_cnt <= '0;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (done_i || w_withdrawn || w_hold_exp) begin
            // gnt_idx_o deliberately keeps the released index.
            r_gnt      <= '0;
            r_last_ptr <= r_gnt_idx;
            r_state    <= ST_IDLE;
            r_timeout  <= w_hold_exp && !done_i && !w_withdrawn;
          end else if (r_hold_cnt != '1) begin
            r_hold_cnt <= r_hold_cnt + HC_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt_o     = r_gnt;
  assign gnt_idx_o = r_gnt_idx;
  assign gnt_val_o = |r_gnt;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (REQ_NUM=5, MAX_HOLD=4) with hand-computed expectations.
module tb_rr_arbiter;

  logic       clk;
  logic       arst_n;
  logic [4:0] req;
  logic       done;
  logic [4:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_val;
  logic       timeout;

  int n_pass  = 0;
  int n_total = 0;

  rr_arbiter #(
    .REQ_NUM  (5),
    .MAX_HOLD (4)
  ) dut (
    .clk_i     (clk),
    .arst_n_i  (arst_n),
    .req_i     (req),
    .done_i    (done),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_val_o (gnt_val),
    .timeout_o (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_o(input string tag, input logic [4:0] eg, input logic [2:0] ei, input logic et);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(ei));
    chk({tag, ".val"}, 32'(gnt_val), 32'(|eg));
    chk({tag, ".tmo"}, 32'(timeout), 32'(et));
  endtask

  task automatic do_reset();
    #1 arst_n = 1'b0;
    #1 chk_o("rst_mid", 5'b0, 3'd0, 1'b0);
    #1 arst_n = 1'b1;
  endtask

  initial begin
    int order [5];
    order = '{0, 2, 4, 0, 2};
    arst_n = 1'b0;
    req    = '0;
    done   = 1'b0;
    #2 chk_o("rst", 5'b0, 3'd0, 1'b0);
    tick();
    chk_o("rst_edge", 5'b0, 3'd0, 1'b0);
    #2 arst_n = 1'b1;

    // Single requester: done on the 3rd grant cycle, bubble, re-grant.
    req = 5'b00001;
    tick(); chk_o("t1_g1", 5'b00001, 3'd0, 1'b0);
    tick(); chk_o("t1_g2", 5'b00001, 3'd0, 1'b0);
    tick(); chk_o("t1_g3", 5'b00001, 3'd0, 1'b0);
    done = 1'b1;
    tick(); chk_o("t1_rel", 5'b00000, 3'd0, 1'b0);
    done = 1'b0;
    tick(); chk_o("t1_regrant", 5'b00001, 3'd0, 1'b0);
    req = 5'b00000;
    tick(); chk_o("t1_wd", 5'b00000, 3'd0, 1'b0);
    tick(); chk_o("t1_idle", 5'b00000, 3'd0, 1'b0);

    // Rotation over 10101 from reset priority.
    do_reset();
    req = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      done = 1'b0;
      tick(); chk_o($sformatf("t2_g%0d", i), 5'b00001 << order[i], 3'(order[i]), 1'b0);
      done = 1'b1;
      tick(); chk_o($sformatf("t2_r%0d", i), 5'b00000, 3'(order[i]), 1'b0);
    end
    done = 1'b0;
    req  = 5'b00000;
    tick(); chk_o("t2_idle", 5'b00000, 3'd2, 1'b0);

    // Hold-limit timeouts, last_ptr=2 so the wrap picks idx 1 first.
    req = 5'b00110;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_o($sformatf("t3_a%0d", i), 5'b00010, 3'd1, 1'b0);
    end
    tick(); chk_o("t3_a_to", 5'b00000, 3'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(); chk_o($sformatf("t3_b%0d", i), 5'b00100, 3'd2, 1'b0);
    end
    tick(); chk_o("t3_b_to", 5'b00000, 3'd2, 1'b1);
    req = 5'b00000;
    tick(); chk_o("t3_idle", 5'b00000, 3'd2, 1'b0);

    // done coincides with the hold limit: no timeout pulse.
    req = 5'b01000;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_o($sformatf("t4_g%0d", i), 5'b01000, 3'd3, 1'b0);
    end
    done = 1'b1;
    req  = 5'b11000;
    tick(); chk_o("t4_rel", 5'b00000, 3'd3, 1'b0);
    done = 1'b0;
    tick(); chk_o("t4_next", 5'b10000, 3'd4, 1'b0);
    req = 5'b00000;
    tick(); chk_o("t4_wd", 5'b00000, 3'd4, 1'b0);

    // Withdrawal release, then other requests ignored while busy.
    req = 5'b00010;
    tick(); chk_o("t5_g1", 5'b00010, 3'd1, 1'b0);
    req = 5'b01000;
    tick(); chk_o("t5_wd", 5'b00000, 3'd1, 1'b0);
    tick(); chk_o("t5_g3", 5'b01000, 3'd3, 1'b0);
    req = 5'b01010;
    tick(); chk_o("t5_hold", 5'b01000, 3'd3, 1'b0);
    req = 5'b00000;
    tick(); chk_o("t5_rel", 5'b00000, 3'd3, 1'b0);

    // Asynchronous reset mid-grant.
    req = 5'b00100;
    tick(); chk_o("t6_g2", 5'b00100, 3'd2, 1'b0);
    #2 arst_n = 1'b0;
    #1 chk_o("t6_async", 5'b00000, 3'd0, 1'b0);
    req = 5'b11111;
    #2 arst_n = 1'b1;
    tick(); chk_o("t6_first", 5'b00001, 3'd0, 1'b0);
    req = 5'b00000;
    tick(); chk_o("t6_wd", 5'b00000, 3'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
